// File: rtl/iq_mag_sq.sv
// Squared magnitude of a signed I/Q pair (I*I + Q*Q) using a bit-serial
// shift-add multiplier: W cycles squaring |I|, then W cycles squaring |Q|.
module iq_mag_sq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   i_in,
  input  logic [W-1:0]   q_in,
  input  logic           din_valid,
  output logic           din_ready,
  output logic [2*W-1:0] dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [1:0]     cstate
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_I = 2'd1,
    SQ_Q = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     mag_i_reg, mag_i_next;
  logic [W-1:0]     mag_q_reg, mag_q_next;
  logic [2*W-1:0]   acc_reg, acc_next;
  logic [2*W-1:0]   dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [W-1:0]     abs_i, abs_q;
  logic [W-1:0]     operand;
  logic [2*W-1:0]   addend;
  logic [2*W-1:0]   acc_sum;
  logic             last_bit;
  logic             accept;

  // Negating -2^(W-1) wraps to the same bit pattern, which read unsigned
  // is exactly 2^(W-1), so W bits are enough for every magnitude.
  assign abs_i = i_in[W-1] ? (~i_in + W'(1)) : i_in;
  assign abs_q = q_in[W-1] ? (~q_in + W'(1)) : q_in;

  assign operand  = (state_reg == SQ_Q) ? mag_q_reg : mag_i_reg;
  assign addend   = operand[cnt_reg] ? ({{W{1'b0}}, operand} << cnt_reg) : '0;
  assign acc_sum  = acc_reg + addend;
  assign last_bit = (cnt_reg == CW'(W - 1));

  assign din_ready = !reset && ((state_reg == IDLE) ||
                                ((state_reg == DONE) && dout_ready));
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_next      = state_reg;
    mag_i_next      = mag_i_reg;
    mag_q_next      = mag_q_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;

    case (state_reg)
      IDLE: ;
      SQ_I: begin
        acc_next = acc_sum;
        cnt_next = cnt_reg + CW'(1);
        if (last_bit) begin
          cnt_next   = '0;
          state_next = SQ_Q;
        end
      end
      SQ_Q: begin
        acc_next = acc_sum;
        cnt_next = cnt_reg + CW'(1);
        if (last_bit) begin
          cnt_next        = '0;
          state_next      = DONE;
          dout_next       = acc_sum;
          dout_valid_next = 1'b1;
        end
      end
      DONE: begin
        if (dout_ready) begin
          dout_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A handoff in DONE with a new sample waiting reloads without a bubble.
    if (accept) begin
      mag_i_next      = abs_i;
      mag_q_next      = abs_q;
      acc_next        = '0;
      cnt_next        = '0;
      dout_valid_next = 1'b0;
      state_next      = SQ_I;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      mag_i_reg      <= '0;
      mag_q_reg      <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mag_i_reg      <= mag_i_next;
      mag_q_reg      <= mag_q_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign cstate     = state_reg;

endmodule

// File: tb/tb_iq_mag_sq.sv
// Directed and randomized checks of iq_mag_sq: latency, corner values,
// backpressure, back-to-back handoff, async reset and a scoreboard run.
module tb_iq_mag_sq;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   i_in, q_in;
  logic           din_valid, din_ready;
  logic [2*W-1:0] dout;
  logic           dout_valid, dout_ready;
  logic [1:0]     cstate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iq_mag_sq #(.W(W)) dut (
    .clk(clk), .reset(reset), .i_in(i_in), .q_in(q_in),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .cstate(cstate)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a sample and hold it until an edge accepts it (bounded).
  task automatic send(input logic [W-1:0] i, input logic [W-1:0] q, output bit ok);
    logic rdy;
    ok = 1'b0;
    i_in = i;
    q_in = q;
    din_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      rdy = din_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    din_valid = 1'b0;
  endtask

  // Count edges until dout_valid is seen, giving up after 200.
  task automatic wait_valid(output int n);
    n = 0;
    while (!dout_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    i_in = '0;
    q_in = '0;
    tick();
    tick();
    checks++;
    if (dout !== 32'd0 || dout_valid !== 1'b0 || cstate !== 2'd0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%0d valid=%b cstate=%0d din_ready=%b, required 0/0/0/0",
               dout, dout_valid, cstate, din_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: din_ready=%b, required 1", din_ready);
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_st;
    dout_ready = 1'b1;
    i_in = 16'd3;
    q_in = 16'd4;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (cstate !== 2'd1) begin
      errors++;
      $display("FAIL basic_accept_state: cstate=%0d, required 1", cstate);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k < 32) begin
        exp_st = (k < 16) ? 2'd1 : 2'd2;
        checks++;
        if (cstate !== exp_st || dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_progress edge %0d: cstate=%0d valid=%b, required %0d/0",
                   k, cstate, dout_valid, exp_st);
        end
      end
    end
    checks++;
    if (dout_valid !== 1'b1 || dout !== 32'd25 || cstate !== 2'd3) begin
      errors++;
      $display("FAIL basic_result: valid=%b dout=%0d cstate=%0d, required 1/25/3",
               dout_valid, dout, cstate);
    end
    $display("txn i=3 q=4 dout=%0d", dout);
    tick();
    checks++;
    if (dout_valid !== 1'b0 || cstate !== 2'd0 || dout !== 32'd25) begin
      errors++;
      $display("FAIL basic_handoff: valid=%b cstate=%0d dout=%0d, required 0/0/25",
               dout_valid, cstate, dout);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   vi [3];
    logic [W-1:0]   vq [3];
    logic [2*W-1:0] ve [3];
    bit ok;
    int n;
    vi[0] = 16'h8000; vq[0] = 16'h8000; ve[0] = 32'h8000_0000;
    vi[1] = 16'h0000; vq[1] = 16'h0000; ve[1] = 32'h0000_0000;
    vi[2] = 16'h7FFF; vq[2] = 16'h8001; ve[2] = 32'h7FFE_0002;
    dout_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      send(vi[t], vq[t], ok);
      wait_valid(n);
      checks++;
      if (!ok || n != 32 || dout !== ve[t]) begin
        errors++;
        $display("FAIL corner %0d: accepted=%b latency=%0d dout=%h, required 1/32/%h",
                 t, ok, n, dout, ve[t]);
      end
      $display("txn i=%h q=%h dout=%h", vi[t], vq[t], dout);
      tick();
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    dout_ready = 1'b0;
    send(16'd100, 16'hFF38, ok);
    wait_valid(n);
    checks++;
    if (!ok || n != 32 || dout !== 32'd50000) begin
      errors++;
      $display("FAIL stall_result: accepted=%b latency=%0d dout=%0d, required 1/32/50000",
               ok, n, dout);
    end
    $display("txn i=100 q=-200 dout=%0d", dout);
    din_valid = 1'b1;
    i_in = 16'd1;
    q_in = 16'd1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 32'd50000 || din_ready !== 1'b0 || cstate !== 2'd3) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%b dout=%0d din_ready=%b cstate=%0d, required 1/50000/0/3",
                 k, dout_valid, dout, din_ready, cstate);
      end
      tick();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: din_ready=%b, required 1", din_ready);
    end
    tick();
    checks++;
    if (cstate !== 2'd0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_handoff: cstate=%0d valid=%b, required 0/0", cstate, dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    dout_ready = 1'b1;
    i_in = 16'd31;
    q_in = 16'hFFFF;
    din_valid = 1'b1;
    tick();
    i_in = 16'd7;
    q_in = 16'd24;
    wait_valid(n);
    checks++;
    if (n != 32 || dout !== 32'd962) begin
      errors++;
      $display("FAIL b2b_first: latency=%0d dout=%0d, required 32/962", n, dout);
    end
    $display("txn i=31 q=-1 dout=%0d", dout);
    tick();
    din_valid = 1'b0;
    checks++;
    if (cstate !== 2'd1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: cstate=%0d valid=%b, required 1/0", cstate, dout_valid);
    end
    wait_valid(n);
    checks++;
    if (n != 32 || dout !== 32'd625) begin
      errors++;
      $display("FAIL b2b_second: latency=%0d dout=%0d, required 32/625", n, dout);
    end
    $display("txn i=7 q=24 dout=%0d", dout);
    tick();
    checks++;
    if (cstate !== 2'd0) begin
      errors++;
      $display("FAIL b2b_idle: cstate=%0d, required 0", cstate);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    dout_ready = 1'b1;
    send(16'd3, 16'd4, ok);
    repeat (20) tick();
    checks++;
    if (!ok || cstate !== 2'd2) begin
      errors++;
      $display("FAIL areset_setup: accepted=%b cstate=%0d, required 1/2", ok, cstate);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dout !== 32'd0 || dout_valid !== 1'b0 || cstate !== 2'd0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: dout=%0d valid=%b cstate=%0d din_ready=%b, required 0/0/0/0",
               dout, dout_valid, cstate, din_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    send(16'd5, 16'd12, ok);
    wait_valid(n);
    checks++;
    if (!ok || n != 32 || dout !== 32'd169) begin
      errors++;
      $display("FAIL areset_recover: accepted=%b latency=%0d dout=%0d, required 1/32/169",
               ok, n, dout);
    end
    $display("txn i=5 q=12 dout=%0d", dout);
    tick();
  endtask

  task automatic test_random();
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] exp_v;
    logic signed [W-1:0] ri, rq;
    longint a, b, e;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 80000) begin
      ri = W'($urandom);
      rq = W'($urandom);
      if ($urandom_range(15) == 0) ri = 16'sh8000;
      if ($urandom_range(15) == 0) rq = 16'sh8000;
      i_in = ri;
      q_in = rq;
      din_valid = (sent < 1000) && ($urandom_range(3) != 0);
      dout_ready = ($urandom_range(1) == 1);
      #1;
      if (din_valid && din_ready) begin
        a = longint'(ri);
        b = longint'(rq);
        e = a * a + b * b;
        exp_q.push_back(e[2*W-1:0]);
        sent++;
      end
      if (dout_valid && dout_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_extra: dout=%h delivered with no sample outstanding", dout);
        end else begin
          exp_v = exp_q.pop_front();
          if (dout !== exp_v) begin
            errors++;
            $display("FAIL random_result %0d: dout=%h, required %h", got, dout, exp_v);
          end
          $display("txn rand %0d dout=%h", got, dout);
        end
      end
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    checks++;
    if (sent != 1000 || got != 1000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_count: sent=%0d received=%0d pending=%0d, required 1000/1000/0",
               sent, got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
